// File: rtl/seq_divider_ctrl.sv
// ----------------------------------------------------------------------------
// seq_divider_ctrl
//
// Sequential restoring divider. It divides a 2N-bit dividend by an N-bit
// divisor and produces one quotient bit per clock. It also handles:
//   - input checking (divide-by-zero, quotient overflow),
//   - a runtime choice of signed or unsigned operands,
//   - sign fix-up of the quotient and remainder,
//   - a Start/Ready handshake.
//
// Parameters:
//   N   divisor / quotient / remainder width (dividend is 2N bits), N >= 2
//   CW  iteration counter width, 2**CW must exceed N
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous active-high reset; aborts any operation
//   Start       request, sampled only in IDLE
//   SignedMode  1 = two's-complement operands, 0 = unsigned; sampled with Start
//   Dividend    2N-bit dividend, sampled with Start
//   Divisor     N-bit divisor, sampled with Start
//   Quotient    N-bit result quotient
//   Remainder   N-bit result remainder (takes the sign of the dividend)
//   Busy        high in every state except IDLE
//   Ready       one-cycle pulse when results and flags are valid
//   DivByZero   divisor was zero
//   Overflow    quotient does not fit N bits (unsigned) or the N-bit signed
//               range (signed)
//
// Sequence:
//   IDLE -> LOAD -> RUN (N cycles) -> FIX -> DONE -> IDLE
//   Error path: IDLE -> LOAD -> DONE -> IDLE
// ----------------------------------------------------------------------------
module seq_divider_ctrl #(
    parameter int N  = 5,
    parameter int CW = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             SignedMode,
    input  logic [2*N-1:0]   Dividend,
    input  logic [N-1:0]     Divisor,
    output logic [N-1:0]     Quotient,
    output logic [N-1:0]     Remainder,
    output logic             Busy,
    output logic             Ready,
    output logic             DivByZero,
    output logic             Overflow
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Largest quotient magnitudes that are representable in N signed bits
    localparam logic [N-1:0] QMAX_POS = {1'b0, {(N-1){1'b1}}};  // 2^(N-1)-1
    localparam logic [N-1:0] QMAX_NEG = {1'b1, {(N-1){1'b0}}};  // 2^(N-1)

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]     state;
    logic [CW-1:0]  cnt;

    logic           mode_q;     // latched SignedMode
    logic [2*N-1:0] dvd_q;      // latched Dividend
    logic [N-1:0]   dvs_q;      // latched Divisor

    logic           qsign;      // quotient must be negated in FIX
    logic           rsign;      // remainder must be negated in FIX
    logic [N-1:0]   dvs_mag;    // divisor magnitude used during RUN

    logic [N:0]     prem;       // partial remainder, one guard bit
    logic [N-1:0]   sreg;       // low dividend bits shifting out, quotient in

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [2*N-1:0] dvd_mag_c;
    logic [N-1:0]   dvs_mag_c;
    logic [N-1:0]   dvd_hi;
    logic [N-1:0]   dvd_lo;

    logic [N+1:0]   rem_sh;     // {prem, sreg} shifted left by one, upper part
    logic [N+1:0]   trial;      // trial subtraction result
    logic           trial_neg;  // trial went negative: restore

    logic [N-1:0]   q_neg;
    logic [N-1:0]   r_neg;
    logic           fix_ovf;

    always_comb begin
        // Magnitudes. In unsigned mode the operands pass through unchanged.
        // For the most negative values the negation wraps to the same bit
        // pattern, which is the correct unsigned magnitude.
        dvd_mag_c = dvd_q;
        dvs_mag_c = dvs_q;
        if (mode_q && dvd_q[2*N-1]) begin
            dvd_mag_c = -dvd_q;
        end
        if (mode_q && dvs_q[N-1]) begin
            dvs_mag_c = -dvs_q;
        end
        dvd_hi = dvd_mag_c[2*N-1:N];
        dvd_lo = dvd_mag_c[N-1:0];
    end

    always_comb begin
        // One restoring step. The extra top bit makes the sign of the trial
        // subtraction directly visible.
        rem_sh    = {prem, sreg[N-1]};
        trial     = rem_sh - {2'b00, dvs_mag};
        trial_neg = trial[N+1];
    end

    always_comb begin
        q_neg   = -sreg;
        r_neg   = -prem[N-1:0];
        // A quotient magnitude of 2^(N-1) is only representable when the
        // quotient is negative.
        fix_ovf = 1'b0;
        if (mode_q) begin
            if (qsign) begin
                fix_ovf = (sreg > QMAX_NEG);
            end else begin
                fix_ovf = (sreg > QMAX_POS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs (decoded from the state)
    // ------------------------------------------------------------------
    assign Busy  = (state != S_IDLE);
    assign Ready = (state == S_DONE);

    // ------------------------------------------------------------------
    // Control and datapath sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dvs_mag   <= '0;
            prem      <= '0;
            sreg      <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        dvd_q     <= Dividend;
                        dvs_q     <= Divisor;
                        mode_q    <= SignedMode;
                        DivByZero <= 1'b0;
                        Overflow  <= 1'b0;
                        state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Signs only matter in signed mode, so unsigned results
                    // pass through FIX untouched.
                    qsign   <= mode_q & (dvd_q[2*N-1] ^ dvs_q[N-1]);
                    rsign   <= mode_q & dvd_q[2*N-1];
                    dvs_mag <= dvs_mag_c;
                    if (dvs_q == '0) begin
                        DivByZero <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= '0;
                        state     <= S_DONE;
                    end else if (dvd_hi >= dvs_mag_c) begin
                        // Quotient magnitude would need more than N bits.
                        Overflow  <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= '0;
                        state     <= S_DONE;
                    end else begin
                        prem  <= {1'b0, dvd_hi};
                        sreg  <= dvd_lo;
                        cnt   <= CW'(N);
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (trial_neg) begin
                        prem <= rem_sh[N:0];
                    end else begin
                        prem <= trial[N:0];
                    end
                    sreg <= {sreg[N-2:0], ~trial_neg};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    Quotient  <= qsign ? q_neg : sreg;
                    Remainder <= rsign ? r_neg : prem[N-1:0];
                    Overflow  <= fix_ovf;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
